// File: rtl/riscv_ppreg_pkg.sv
// rtl/riscv_ppreg_pkg.sv - shared types and defaults for the pipeline-stage skid register
package riscv_ppreg_pkg;

  typedef enum logic [1:0] {PPREG_EMPTY, PPREG_ONE, PPREG_TWO} ppreg_state_t;

  localparam int PPREG_DATA_W_DEF = 64;
  localparam int PPREG_CNT_W_DEF  = 16;

endpackage

// File: rtl/riscv_ppreg_skid_if.sv
// rtl/riscv_ppreg_skid_if.sv - upstream/downstream valid-ready payload bus of the stage register
interface riscv_ppreg_skid_if
  import riscv_ppreg_pkg::*;
#(
  parameter int DATA_W = PPREG_DATA_W_DEF
);

  logic              i_riscv_ppreg_valid_u;
  logic              o_riscv_ppreg_ready_u;
  logic [DATA_W-1:0] i_riscv_ppreg_data_u;
  logic              o_riscv_ppreg_valid_d;
  logic              i_riscv_ppreg_ready_d;
  logic [DATA_W-1:0] o_riscv_ppreg_data_d;

  modport master (
    output i_riscv_ppreg_valid_u, i_riscv_ppreg_data_u, i_riscv_ppreg_ready_d,
    input  o_riscv_ppreg_ready_u, o_riscv_ppreg_valid_d, o_riscv_ppreg_data_d
  );

  modport slave (
    input  i_riscv_ppreg_valid_u, i_riscv_ppreg_data_u, i_riscv_ppreg_ready_d,
    output o_riscv_ppreg_ready_u, o_riscv_ppreg_valid_d, o_riscv_ppreg_data_d
  );

endinterface

// File: rtl/riscv_ppreg_satcnt.sv
// rtl/riscv_ppreg_satcnt.sv - saturating counter, only built with RISCV_PPREG_STALLCNT_EN
`ifdef RISCV_PPREG_STALLCNT_EN
module riscv_ppreg_satcnt #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule
`endif

// File: rtl/riscv_ppreg_skid.sv
// rtl/riscv_ppreg_skid.sv - 2-entry skid pipeline-stage register with flush
// Optional stall counter enabled by RISCV_PPREG_STALLCNT_EN.
module riscv_ppreg_skid
  import riscv_ppreg_pkg::*;
#(
  parameter int DATA_W       = PPREG_DATA_W_DEF,
  parameter bit CLR_ON_FLUSH = 1'b1,
  parameter int CNT_W        = PPREG_CNT_W_DEF
) (
  input  logic                i_riscv_ppreg_clk,
  input  logic                i_riscv_ppreg_rst,
  input  logic                i_riscv_ppreg_flush,
  riscv_ppreg_skid_if.slave   bus,
  output logic [CNT_W-1:0]    o_riscv_ppreg_stallcnt
);

  ppreg_state_t      state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              ready_u, valid_d;
  logic              in_fire, out_fire;

  assign in_fire  = bus.i_riscv_ppreg_valid_u & ready_u;
  assign out_fire = valid_d & bus.i_riscv_ppreg_ready_d;

  always_ff @(posedge i_riscv_ppreg_clk or negedge i_riscv_ppreg_rst) begin
    if (!i_riscv_ppreg_rst) begin
      state_q <= PPREG_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (i_riscv_ppreg_flush) begin
      // A same-cycle out_fire is still consumed downstream; the input is dropped.
      state_d = PPREG_EMPTY;
      if (CLR_ON_FLUSH) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      unique case (state_q)
        PPREG_EMPTY: begin
          if (in_fire) begin
            state_d = PPREG_ONE;
            main_d  = bus.i_riscv_ppreg_data_u;
          end
        end
        PPREG_ONE: begin
          if (in_fire && out_fire) begin
            main_d = bus.i_riscv_ppreg_data_u;
          end else if (in_fire) begin
            state_d = PPREG_TWO;
            skid_d  = bus.i_riscv_ppreg_data_u;
          end else if (out_fire) begin
            state_d = PPREG_EMPTY;
          end
        end
        PPREG_TWO: begin
          if (out_fire) begin
            state_d = PPREG_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = PPREG_EMPTY;
      endcase
    end
  end

  // Outputs decode registered state only, so ready_d never reaches ready_u.
  always_comb begin
    ready_u = (state_q != PPREG_TWO);
    valid_d = (state_q != PPREG_EMPTY);
  end

  assign bus.o_riscv_ppreg_ready_u = ready_u;
  assign bus.o_riscv_ppreg_valid_d = valid_d;
  assign bus.o_riscv_ppreg_data_d  = main_q;

`ifdef RISCV_PPREG_STALLCNT_EN
  riscv_ppreg_satcnt #(.W(CNT_W)) u_stallcnt (
    .clk_i   (i_riscv_ppreg_clk),
    .rst_ni  (i_riscv_ppreg_rst),
    .inc_i   (bus.i_riscv_ppreg_valid_u & ~ready_u),
    .count_o (o_riscv_ppreg_stallcnt)
  );
`else
  assign o_riscv_ppreg_stallcnt = '0;
`endif

endmodule

// File: tb/tb_riscv_ppreg_skid.sv
// tb/tb_riscv_ppreg_skid.sv - self-checking bench for riscv_ppreg_skid
module tb_riscv_ppreg_skid;

  localparam int DW = 64;
  localparam int CW = 4;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          rd;
    logic          fl;
    logic          e_rdy;
    logic          e_vld;
    logic          e_zero;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [CW-1:0] stallcnt;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] sb_q[$];
  logic [CW-1:0] exp_cnt = '0;
  vec_t          vecs[$];

  riscv_ppreg_skid_if #(.DATA_W(DW)) bus ();

  riscv_ppreg_skid #(.DATA_W(DW), .CLR_ON_FLUSH(1'b1), .CNT_W(CW)) dut (
    .i_riscv_ppreg_clk      (clk),
    .i_riscv_ppreg_rst      (rst_n),
    .i_riscv_ppreg_flush    (flush),
    .bus                    (bus),
    .o_riscv_ppreg_stallcnt (stallcnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; drives one cycle, checks against the scoreboard, crosses the edge.
  task automatic apply(input logic v, input logic [DW-1:0] d, input logic rd, input logic fl);
    int  sz;
    logic infire;
    bus.i_riscv_ppreg_valid_u = v;
    bus.i_riscv_ppreg_data_u  = d;
    bus.i_riscv_ppreg_ready_d = rd;
    flush = fl;
    sz = sb_q.size();
    chk("ready_u", DW'(bus.o_riscv_ppreg_ready_u), DW'(sz < 2));
    chk("valid_d", DW'(bus.o_riscv_ppreg_valid_d), DW'(sz > 0));
    chk("stallcnt", DW'(stallcnt), DW'(exp_cnt));
    infire = v && (sz < 2);
    if (v && (sz == 2)) begin
`ifdef RISCV_PPREG_STALLCNT_EN
      if (exp_cnt != CNT_MAX) exp_cnt = exp_cnt + CW'(1);
`endif
    end
    if (sz > 0 && rd) begin
      chk("data_d", bus.o_riscv_ppreg_data_d, sb_q[0]);
      void'(sb_q.pop_front());
    end
    if (fl) sb_q.delete();
    else if (infire) sb_q.push_back(d);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.i_riscv_ppreg_valid_u = 1'b1;
    bus.i_riscv_ppreg_data_u  = 64'hDEAD;
    bus.i_riscv_ppreg_ready_d = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst valid_d", DW'(bus.o_riscv_ppreg_valid_d), '0);
    chk("rst data_d", bus.o_riscv_ppreg_data_d, '0);
    chk("rst ready_u", DW'(bus.o_riscv_ppreg_ready_u), DW'(1));
    chk("rst stallcnt", DW'(stallcnt), '0);
    rst_n = 1'b1;
    bus.i_riscv_ppreg_valid_u = 1'b0;

    //               v  data    rd fl  rdy vld zero
    vecs.push_back('{1, 64'd7688, 1, 0, 1, 1, 0});
    vecs.push_back('{1, 64'd980,  1, 0, 1, 1, 0});
    vecs.push_back('{1, 64'd689,  1, 0, 1, 1, 0});
    vecs.push_back('{0, 64'd0,    1, 0, 1, 0, 0});
    vecs.push_back('{1, 64'd567,  0, 0, 1, 1, 0});
    vecs.push_back('{1, 64'd8808, 0, 0, 0, 1, 0});
    vecs.push_back('{1, 64'd3,    0, 0, 0, 1, 0});
    vecs.push_back('{1, 64'd3,    0, 0, 0, 1, 0});
    vecs.push_back('{1, 64'd3,    1, 0, 1, 1, 0});
    vecs.push_back('{1, 64'd3,    1, 0, 1, 1, 0});
    vecs.push_back('{0, 64'd0,    1, 0, 1, 0, 0});
    vecs.push_back('{1, 64'd100,  0, 0, 1, 1, 0});
    vecs.push_back('{1, 64'd200,  0, 0, 0, 1, 0});
    vecs.push_back('{1, 64'd42,   0, 1, 1, 0, 1});
    vecs.push_back('{0, 64'd0,    1, 0, 1, 0, 1});
    vecs.push_back('{1, 64'd55,   0, 0, 1, 1, 0});
    vecs.push_back('{0, 64'd0,    1, 1, 1, 0, 1});
    vecs.push_back('{1, 64'd66,   1, 0, 1, 1, 0});
    vecs.push_back('{0, 64'd0,    1, 0, 1, 0, 0});

    foreach (vecs[i]) begin
      apply(vecs[i].v, vecs[i].d, vecs[i].rd, vecs[i].fl);
      chk($sformatf("vec%0d ready_u", i), DW'(bus.o_riscv_ppreg_ready_u), DW'(vecs[i].e_rdy));
      chk($sformatf("vec%0d valid_d", i), DW'(bus.o_riscv_ppreg_valid_d), DW'(vecs[i].e_vld));
      if (vecs[i].e_zero) chk($sformatf("vec%0d data_d zero", i), bus.o_riscv_ppreg_data_d, '0);
    end
    chk("sb empty after table", DW'(sb_q.size()), '0);

    // Fill both entries, then hold a stalled upstream for 20 cycles.
    apply(1'b1, 64'd1001, 1'b0, 1'b0);
    apply(1'b1, 64'd1002, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) apply(1'b1, 64'd1003, 1'b0, 1'b0);
`ifdef RISCV_PPREG_STALLCNT_EN
    chk("stallcnt saturated", DW'(stallcnt), DW'(CNT_MAX));
`else
    chk("stallcnt tied off", DW'(stallcnt), '0);
`endif
    apply(1'b1, 64'd1003, 1'b1, 1'b0);
    apply(1'b1, 64'd1003, 1'b1, 1'b0);
    apply(1'b0, 64'd0, 1'b1, 1'b0);
    apply(1'b0, 64'd0, 1'b1, 1'b0);
    chk("sb empty after drain", DW'(sb_q.size()), '0);

    // Asynchronous reset between edges while holding one entry.
    apply(1'b1, 64'd77, 1'b0, 1'b0);
    bus.i_riscv_ppreg_valid_u = 1'b0;
    chk("pre-arst valid_d", DW'(bus.o_riscv_ppreg_valid_d), DW'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("arst valid_d", DW'(bus.o_riscv_ppreg_valid_d), '0);
    chk("arst ready_u", DW'(bus.o_riscv_ppreg_ready_u), DW'(1));
    chk("arst data_d", bus.o_riscv_ppreg_data_d, '0);
    chk("arst stallcnt", DW'(stallcnt), '0);
    sb_q.delete();
    exp_cnt = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    apply(1'b1, 64'd88, 1'b1, 1'b0);
    apply(1'b0, 64'd0, 1'b1, 1'b0);
    chk("sb empty at end", DW'(sb_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
